// File: rtl/algorithm_reduce.sv
// Stream reduction: folds one element stream into a single accumulator
// using wrap sum, saturating sum, min or max, with count and overflow.
module algorithm_reduce #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 8,
  parameter int MODE        = 0,
  parameter int SIGNED      = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       sIn,
  input  logic                   sIn_valid,
  input  logic                   sIn_last,
  output logic                   sIn_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int MSB = ACC_WIDTH - 1;

  localparam bit SGN    = (SIGNED != 0);
  localparam bit IS_SAT = (MODE == 1);
  localparam bit IS_MIN = (MODE == 2);
  localparam bit IS_MAX = (MODE == 3);

  localparam logic [ACC_WIDTH-1:0] ACC_ONES = '1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    SGN ? (ACC_ONES >> 1) : ACC_ONES;
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    SGN ? ~(ACC_ONES >> 1) : '0;
  localparam logic [ACC_WIDTH-1:0] IDENT =
    IS_MIN ? ACC_MAX : (IS_MAX ? ACC_MIN : '0);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_nxt;
  logic [COUNT_WIDTH-1:0] cnt_nxt;
  logic                   ovf_nxt;

  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH:0]     add_w;
  logic [ACC_WIDTH-1:0]   add;
  logic                   ovf_add;
  logic [ACC_WIDTH-1:0]   clamp_val;
  logic                   ext_lt;
  logic                   ext_gt;
  logic [ACC_WIDTH-1:0]   acc_step;
  logic                   ovf_step;

  always_comb begin
    ext = '0;
    ext[WIDTH-1:0] = sIn;
    for (int i = WIDTH; i < ACC_WIDTH; i++) begin
      ext[i] = SGN & sIn[WIDTH-1];
    end
  end

  assign add_w = {1'b0, acc} + {1'b0, ext};
  assign add   = add_w[MSB:0];

  // Signed overflow: operands agree in sign, result does not.
  assign ovf_add = SGN
    ? ((acc[MSB] == ext[MSB]) && (add[MSB] != acc[MSB]))
    : add_w[ACC_WIDTH];

  assign clamp_val = (SGN && ext[MSB]) ? ACC_MIN : ACC_MAX;

  // Flipping the sign bit maps signed order onto unsigned order.
  assign ext_lt = (ext ^ ACC_MIN) < (acc ^ ACC_MIN);
  assign ext_gt = (ext ^ ACC_MIN) > (acc ^ ACC_MIN);

  always_comb begin
    acc_step = add;
    ovf_step = 1'b0;
    unique case (1'b1)
      IS_MIN: begin
        acc_step = ext_lt ? ext : acc;
      end
      IS_MAX: begin
        acc_step = ext_gt ? ext : acc;
      end
      IS_SAT: begin
        acc_step = ovf_add ? clamp_val : add;
        ovf_step = ovf_add;
      end
      default: begin
        acc_step = add;
        ovf_step = ovf_add;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = count;
    ovf_nxt   = overflow;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_RUN;
          acc_nxt   = IDENT;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (sIn_valid) begin
          acc_nxt = acc_step;
          ovf_nxt = overflow | ovf_step;
          if (!(&count)) begin
            cnt_nxt = count + COUNT_WIDTH'(1);
          end
        end
        if (sIn_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      count    <= cnt_nxt;
      overflow <= ovf_nxt;
      sum      <= (state_nxt == S_DONE) ? acc_nxt : '0;
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign sIn_ready = (state == S_RUN);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_algorithm_reduce.sv
// Bench for algorithm_reduce: several parameterisations share one
// stimulus stream and are checked against an arithmetic reference model.
module tb_algorithm_reduce;

  localparam int NI = 11;

  // Packed config word: mode[31:24] signed[23:16] acc_w[15:8] cnt_w[7:0]
  function automatic int cfg(int g);
    case (g)
      0:       return {8'd0, 8'd0, 8'd8,  8'd16};
      1:       return {8'd0, 8'd0, 8'd16, 8'd16};
      2:       return {8'd1, 8'd0, 8'd8,  8'd16};
      3:       return {8'd2, 8'd1, 8'd8,  8'd16};
      4:       return {8'd3, 8'd0, 8'd8,  8'd16};
      5:       return {8'd3, 8'd1, 8'd8,  8'd16};
      6:       return {8'd1, 8'd1, 8'd8,  8'd16};
      7:       return {8'd0, 8'd1, 8'd8,  8'd16};
      8:       return {8'd0, 8'd0, 8'd8,  8'd2};
      9:       return {8'd5, 8'd1, 8'd16, 8'd16};
      default: return {8'd2, 8'd0, 8'd16, 8'd16};
    endcase
  endfunction

  function automatic int cfg_mode(int g);
    return (cfg(g) >> 24) & 255;
  endfunction
  function automatic int cfg_sg(int g);
    return (cfg(g) >> 16) & 255;
  endfunction
  function automatic int cfg_aw(int g);
    return (cfg(g) >> 8) & 255;
  endfunction
  function automatic int cfg_cw(int g);
    return cfg(g) & 255;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] sIn;
  logic       sIn_valid;
  logic       sIn_last;
  logic       out_ready;

  logic        ir_o  [NI];
  logic        sr_o  [NI];
  logic        ov_o  [NI];
  logic        ovf_o [NI];
  logic [15:0] sum_o [NI];
  logic [15:0] cnt_o [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int AW = cfg_aw(g);
    localparam int CW = cfg_cw(g);
    logic [AW-1:0] s;
    logic [CW-1:0] c;
    algorithm_reduce #(
      .WIDTH(8),
      .ACC_WIDTH(AW),
      .MODE(cfg_mode(g)),
      .SIGNED(cfg_sg(g)),
      .COUNT_WIDTH(CW)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(ir_o[g]),
      .sIn(sIn),
      .sIn_valid(sIn_valid),
      .sIn_last(sIn_last),
      .sIn_ready(sr_o[g]),
      .out_valid(ov_o[g]),
      .out_ready(out_ready),
      .sum(s),
      .count(c),
      .overflow(ovf_o[g])
    );
    assign sum_o[g] = 16'(s);
    assign cnt_o[g] = 16'(c);
  end

  int checks   = 0;
  int failures = 0;
  int xs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int g, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the whole element list.
  function automatic void model(input int g, output longint res,
                                output longint cnt, output bit ovf);
    int md;
    bit sg;
    longint r, lo, hi, v, e, cmax;
    md = cfg_mode(g);
    sg = cfg_sg(g) != 0;
    r  = longint'(1) << cfg_aw(g);
    if (sg) begin
      lo = -(r / 2);
      hi = r / 2 - 1;
    end else begin
      lo = 0;
      hi = r - 1;
    end
    v   = (md == 2) ? hi : ((md == 3) ? lo : 0);
    ovf = 1'b0;
    foreach (xs[i]) begin
      e = (sg && xs[i] >= 128) ? longint'(xs[i]) - 256 : longint'(xs[i]);
      case (md)
        1: begin
          v = v + e;
          if (v > hi) begin v = hi; ovf = 1'b1; end
          else if (v < lo) begin v = lo; ovf = 1'b1; end
        end
        2: if (e < v) v = e;
        3: if (e > v) v = e;
        default: begin
          v = v + e;
          if (v > hi) begin v = v - r; ovf = 1'b1; end
          else if (v < lo) begin v = v + r; ovf = 1'b1; end
        end
      endcase
    end
    res  = v & (r - 1);
    cmax = (longint'(1) << cfg_cw(g)) - 1;
    cnt  = (xs.size() > cmax) ? cmax : longint'(xs.size());
  endfunction

  task automatic check_done();
    longint res, cnt;
    bit ovf;
    for (int g = 0; g < NI; g++) begin
      model(g, res, cnt, ovf);
      chk("out_valid", g, longint'(ov_o[g]), 1);
      chk("in_ready_done", g, longint'(ir_o[g]), 0);
      chk("sum", g, longint'(sum_o[g]), res);
      chk("count", g, longint'(cnt_o[g]), cnt);
      chk("overflow", g, longint'(ovf_o[g]), longint'(ovf));
    end
  endtask

  task automatic check_idle(string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_in_ready"}, g, longint'(ir_o[g]), 1);
      chk({tag, "_out_valid"}, g, longint'(ov_o[g]), 0);
      chk({tag, "_sIn_ready"}, g, longint'(sr_o[g]), 0);
      chk({tag, "_sum"}, g, longint'(sum_o[g]), 0);
    end
  endtask

  task automatic run_txn(bit bare_in, bit rnd, int gap_last,
                         int hold, bit dv);
    int  n;
    int  k;
    int  gp;
    bit  bare;
    n    = xs.size();
    bare = bare_in || (n == 0);
    k    = 0;
    while (!ir_o[0] && k < 20) begin
      tick();
      k++;
    end
    chk("start_wait", 0, longint'(ir_o[0]), 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("run_sIn_ready", 0, longint'(sr_o[0]), 1);
    for (int i = 0; i < n; i++) begin
      gp = (i == n - 1) ? gap_last : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (gp) begin
        sIn_valid = 1'b0;
        sIn_last  = 1'b0;
        tick();
      end
      sIn       = 8'(xs[i]);
      sIn_valid = 1'b1;
      sIn_last  = (i == n - 1) && !bare;
      tick();
    end
    sIn_valid = 1'b0;
    sIn_last  = 1'b0;
    if (bare) begin
      sIn_last = 1'b1;
      tick();
      sIn_last = 1'b0;
    end
    check_done();
    in_valid = dv;
    repeat (hold) begin
      tick();
      check_done();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_idle("release");
    if (dv) begin
      tick();
      in_valid = 1'b0;
      chk("late_start", 0, longint'(sr_o[0]), 1);
      xs.delete();
      sIn_last = 1'b1;
      tick();
      sIn_last = 1'b0;
      check_done();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_idle("release2");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    sIn       = '0;
    sIn_valid = 1'b0;
    sIn_last  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready", g, longint'(ir_o[g]), 0);
      chk("rst_out_valid", g, longint'(ov_o[g]), 0);
      chk("rst_count", g, longint'(cnt_o[g]), 0);
      chk("rst_overflow", g, longint'(ovf_o[g]), 0);
      chk("rst_sum", g, longint'(sum_o[g]), 0);
    end
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    xs = '{1, 2, 3, 255};
    run_txn(0, 0, 0, 0, 0);
    xs = '{200, 100};
    run_txn(0, 0, 0, 0, 0);
    xs = '{10, 20};
    run_txn(0, 0, 0, 0, 0);
    xs = '{5, 253, 7};
    run_txn(0, 0, 0, 1, 0);
    xs.delete();
    run_txn(1, 0, 0, 0, 0);
    xs = '{4, 6};
    run_txn(0, 0, 2, 3, 0);
    xs = '{1, 2};
    run_txn(0, 0, 0, 1, 1);

    xs = '{3, 4};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    foreach (xs[i]) begin
      sIn       = 8'(xs[i]);
      sIn_valid = 1'b1;
      tick();
    end
    sIn_valid = 1'b0;
    rst       = 1'b1;
    tick();
    for (int g = 0; g < NI; g++) begin
      chk("mid_rst_in_ready", g, longint'(ir_o[g]), 0);
      chk("mid_rst_sIn_ready", g, longint'(sr_o[g]), 0);
      chk("mid_rst_count", g, longint'(cnt_o[g]), 0);
      chk("mid_rst_overflow", g, longint'(ovf_o[g]), 0);
    end
    rst = 1'b0;
    tick();
    check_idle("after_mid_rst");
    xs = '{9};
    run_txn(0, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(0, 8);
      xs.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          xs.push_back(($urandom_range(0, 1) == 1) ? 255 : 128);
        end else begin
          xs.push_back(int'($urandom_range(0, 255)));
        end
      end
      run_txn(bit'($urandom_range(0, 1)), 1'b1,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
